// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter that shares one spi_master among N_REQ requesters.
// Optional watchdog abort (err port) is enabled by defining SPI_ARB_WATCHDOG_EN.
module spi_arbiter #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned WDOG_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [6*N_REQ-1:0]         req_words,
   input  logic [N_REQ-1:0]           req_tied,
   input  logic [DATA_BITS*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]           gnt,
   output logic [N_REQ-1:0]           rx_valid,
   output logic [DATA_BITS-1:0]       rx_data,
   output logic [N_REQ-1:0]           done,
`ifdef SPI_ARB_WATCHDOG_EN
   output logic [N_REQ-1:0]           err,
`endif
   output logic                       m_spi_en,
   output logic                       m_tied_SS,
   output logic [DATA_BITS-1:0]       m_data_in,
   output logic [5:0]                 m_data_words,
   input  logic                       m_ready,
   input  logic                       m_valid,
   input  logic [DATA_BITS-1:0]       m_data_out
);

   localparam int unsigned IDX_W  = $clog2(N_REQ);
   localparam int unsigned WORD_W = 6;

   if (N_REQ < 2 || N_REQ > 8 || WDOG_CYCLES == 0) begin : g_param_check
      $error("spi_arbiter: N_REQ must be 2..8 and WDOG_CYCLES nonzero");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    last_q;
   logic [IDX_W-1:0]    win_q;
   logic [WORD_W-1:0]   word_cnt;
   logic                mv_q;

   logic                win_found;
   logic [IDX_W-1:0]    win_idx;
   logic [IDX_W-1:0]    cand;
   logic [WORD_W-1:0]   win_words;
   logic                win_tied;
   logic                mv_edge;

   assign mv_edge = m_valid & ~mv_q;

   // Round-robin search starting one past the last served requester
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = IDX_W'((32'(last_q) + i) % N_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Winner's control fields and the granted requester's TX word
   always_comb begin
      win_words = '0;
      win_tied  = 1'b0;
      m_data_in = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win_idx == IDX_W'(i)) begin
            win_words = req_words[WORD_W*i +: WORD_W];
            win_tied  = req_tied[i];
         end
         if (gnt[i]) begin
            m_data_in = m_data_in | req_data[DATA_BITS*i +: DATA_BITS];
         end
      end
   end

`ifdef SPI_ARB_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
`endif

   // m_data_words doubles as the latched word count W for the transaction
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= IDLE;
         gnt          <= '0;
         rx_valid     <= '0;
         rx_data      <= '0;
         done         <= '0;
         m_spi_en     <= 1'b0;
         m_tied_SS    <= 1'b0;
         m_data_words <= '0;
         word_cnt     <= '0;
         last_q       <= IDX_W'(N_REQ - 1);
         win_q        <= '0;
         mv_q         <= 1'b0;
`ifdef SPI_ARB_WATCHDOG_EN
         err          <= '0;
         wd_cnt       <= '0;
`endif
      end else begin
         rx_valid <= '0;
         done     <= '0;
         m_spi_en <= 1'b0;
         mv_q     <= m_valid;
`ifdef SPI_ARB_WATCHDOG_EN
         err      <= '0;
`endif
         case (state)
            IDLE: begin
               if (m_ready && win_found) begin
                  gnt          <= N_REQ'(1) << win_idx;
                  win_q        <= win_idx;
                  m_spi_en     <= 1'b1;
                  m_data_words <= (win_words == '0) ? WORD_W'(1) : win_words;
                  m_tied_SS    <= win_tied;
                  word_cnt     <= '0;
`ifdef SPI_ARB_WATCHDOG_EN
                  wd_cnt       <= '0;
`endif
                  state        <= START;
               end
            end
            START: begin
`ifdef SPI_ARB_WATCHDOG_EN
               wd_cnt <= wd_cnt + WD_W'(1);
`endif
               state  <= BUSY;
            end
            BUSY: begin
               if (mv_edge) begin
                  word_cnt <= word_cnt + WORD_W'(1);
                  rx_valid <= gnt;
                  rx_data  <= m_data_out;
`ifdef SPI_ARB_WATCHDOG_EN
                  wd_cnt   <= '0;
`endif
                  if (word_cnt + WORD_W'(1) == m_data_words) begin
                     done  <= gnt;
                     state <= DONE;
                  end
               end
`ifdef SPI_ARB_WATCHDOG_EN
               else if (wd_cnt == WD_W'(WDOG_CYCLES - 1)) begin
                  err    <= gnt;
                  gnt    <= '0;
                  last_q <= win_q;
                  state  <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
`endif
            end
            DONE: begin
               gnt    <= '0;
               last_q <= win_q;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: table-driven bench for spi_arbiter with a loopback spi_master model.
// Watchdog sequence is included when SPI_ARB_WATCHDOG_EN is defined.
module tb_spi_arbiter;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned DB    = 8;
   localparam int unsigned WDOG  = 16;

   logic                  clk = 1'b0;
   logic                  n_rst;
   logic [N_REQ-1:0]      req;
   logic [6*N_REQ-1:0]    req_words;
   logic [N_REQ-1:0]      req_tied;
   logic [DB*N_REQ-1:0]   req_data;
   logic [N_REQ-1:0]      gnt;
   logic [N_REQ-1:0]      rx_valid;
   logic [DB-1:0]         rx_data;
   logic [N_REQ-1:0]      done;
   logic                  m_spi_en;
   logic                  m_tied_SS;
   logic [DB-1:0]         m_data_in;
   logic [5:0]            m_data_words;
   logic                  m_ready;
   logic                  m_valid;
   logic [DB-1:0]         m_data_out;
`ifdef SPI_ARB_WATCHDOG_EN
   logic [N_REQ-1:0]      err;
   int                    err_cnt;
   int                    err_lat;
   int                    err_q[$];
`endif

   spi_arbiter #(
      .N_REQ       (N_REQ),
      .DATA_BITS   (DB),
      .WDOG_CYCLES (WDOG)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .req          (req),
      .req_words    (req_words),
      .req_tied     (req_tied),
      .req_data     (req_data),
      .gnt          (gnt),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .done         (done),
`ifdef SPI_ARB_WATCHDOG_EN
      .err          (err),
`endif
      .m_spi_en     (m_spi_en),
      .m_tied_SS    (m_tied_SS),
      .m_data_in    (m_data_in),
      .m_data_words (m_data_words),
      .m_ready      (m_ready),
      .m_valid      (m_valid),
      .m_data_out   (m_data_out)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  tx_base [N_REQ];
   int          rx_cnt [N_REQ];
   int          done_cnt [N_REQ];
   int          spi_en_cnt;
   int          multi_bad;
   int          ctl_bad;
   int          cyc = 0;
   int          spi_cyc = 0;
   int          order_q[$];
   logic [N_REQ-1:0] gnt_prev;
   logic        exp_tied = 1'b0;
   logic [5:0]  exp_w = 6'd1;
   int          hang = 0;
   int          inject_req = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: counts DUT events and checks received data against the loopback expectation
   initial begin
      gnt_prev = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!n_rst) begin
            for (int i = 0; i < N_REQ; i++) begin
               rx_cnt[i]   = 0;
               done_cnt[i] = 0;
            end
            spi_en_cnt = 0;
            multi_bad  = 0;
            ctl_bad    = 0;
            order_q.delete();
`ifdef SPI_ARB_WATCHDOG_EN
            err_cnt = 0;
            err_lat = 0;
            err_q.delete();
`endif
         end else begin
            if ($countones(gnt) > 1) multi_bad++;
            if (gnt != '0 && gnt_prev == '0) begin
               for (int i = 0; i < N_REQ; i++) if (gnt[i]) order_q.push_back(i);
            end
            if (gnt != '0 && (m_tied_SS !== exp_tied || m_data_words !== exp_w)) ctl_bad++;
            if (m_spi_en === 1'b1) begin
               spi_en_cnt++;
               spi_cyc = cyc;
            end
            for (int i = 0; i < N_REQ; i++) begin
               if (rx_valid[i] === 1'b1) begin
                  check("rx_data", 32'(rx_data), 32'(8'(tx_base[i] + 8'(rx_cnt[i]))));
                  rx_cnt[i]++;
               end
               if (done[i] === 1'b1) done_cnt[i]++;
`ifdef SPI_ARB_WATCHDOG_EN
               if (err[i] === 1'b1) begin
                  err_cnt++;
                  err_q.push_back(i);
                  err_lat = cyc - spi_cyc;
               end
`endif
            end
         end
         gnt_prev = gnt;
      end
   end

   // Requesters: present base+k as word k, advancing after each received word
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N_REQ; i++) req_data[DB*i +: DB] = 8'(tx_base[i] + 8'(rx_cnt[i]));
      end
   end

   // spi_master model: MISO looped to MOSI, one m_valid pulse per word
   initial begin
      int nw;
      int inject_seen;
      inject_seen = 0;
      m_ready    = 1'b1;
      m_valid    = 1'b0;
      m_data_out = '0;
      forever begin
         @(posedge clk);
         #1;
         if (inject_req != inject_seen) begin
            inject_seen = inject_req;
            m_data_out  = 8'h3C;
            m_valid     = 1'b1;
            @(posedge clk);
            #1;
            m_valid = 1'b0;
         end else if (m_spi_en === 1'b1 && hang == 0) begin
            nw      = int'(m_data_words);
            m_ready = 1'b0;
            for (int k = 0; k < nw; k++) begin
               repeat (3) @(posedge clk);
               #1;
               m_data_out = m_data_in;
               m_valid    = 1'b1;
               @(posedge clk);
               #1;
               m_valid = 1'b0;
            end
            m_ready = 1'b1;
         end
      end
   end

   task automatic do_reset();
      n_rst = 1'b0;
      req   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_spi_en", 32'(m_spi_en), 32'd0);
      check("rst_words", 32'(m_data_words), 32'd0);
      check("rst_tied", 32'(m_tied_SS), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_data_in", 32'(m_data_in), 32'd0);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int n;
      n = 0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk);
         #1;
         n = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
         if (n >= target) break;
      end
      check({name, "_done_reached"}, 32'(n >= target), 32'd1);
   endtask

   typedef struct packed {
      logic [3:0]  req;
      logic [5:0]  words;
      logic        tied;
      logic [5:0]  exp_w;
      logic [7:0]  n_done;
      logic [7:0]  exp_en;
      logic [15:0] exp_rx;
      logic [15:0] exp_done;
      logic [3:0]  n_order;
      logic [19:0] order;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int ok;
      vecs[0] = '{req: 4'b0001, words: 6'd1, tied: 1'b0, exp_w: 6'd1, n_done: 8'd1, exp_en: 8'd1,
                  exp_rx: 16'h0001, exp_done: 16'h0001, n_order: 4'd1, order: 20'h00000};
      vecs[1] = '{req: 4'b1111, words: 6'd1, tied: 1'b0, exp_w: 6'd1, n_done: 8'd5, exp_en: 8'd5,
                  exp_rx: 16'h1112, exp_done: 16'h1112, n_order: 4'd5, order: 20'h03210};
      vecs[2] = '{req: 4'b0100, words: 6'd3, tied: 1'b1, exp_w: 6'd3, n_done: 8'd1, exp_en: 8'd1,
                  exp_rx: 16'h0300, exp_done: 16'h0100, n_order: 4'd1, order: 20'h00002};
      vecs[3] = '{req: 4'b1000, words: 6'd0, tied: 1'b0, exp_w: 6'd1, n_done: 8'd1, exp_en: 8'd1,
                  exp_rx: 16'h1000, exp_done: 16'h1000, n_order: 4'd1, order: 20'h00003};
      vecs[4] = '{req: 4'b0110, words: 6'd2, tied: 1'b0, exp_w: 6'd2, n_done: 8'd2, exp_en: 8'd2,
                  exp_rx: 16'h0220, exp_done: 16'h0110, n_order: 4'd2, order: 20'h00021};
      tx_base[0] = 8'hA5;
      tx_base[1] = 8'h5A;
      tx_base[2] = 8'hC0;
      tx_base[3] = 8'h30;
      n_rst     = 1'b0;
      req       = '0;
      req_words = '0;
      req_tied  = '0;

      for (int v = 0; v < 5; v++) begin
         exp_w    = vecs[v].exp_w;
         exp_tied = vecs[v].tied;
         do_reset();
         req_words = {N_REQ{vecs[v].words}};
         req_tied  = {N_REQ{vecs[v].tied}};
         req       = vecs[v].req;
         wait_done(int'(vecs[v].n_done), 600, "vec");
         req = '0;
         repeat (6) @(posedge clk);
         #1;
         check("spi_en_count", 32'(spi_en_cnt), 32'(vecs[v].exp_en));
         for (int i = 0; i < N_REQ; i++) begin
            check("rx_count", 32'(rx_cnt[i]), 32'(vecs[v].exp_rx[4*i +: 4]));
            check("done_count", 32'(done_cnt[i]), 32'(vecs[v].exp_done[4*i +: 4]));
         end
         check("order_len", 32'(order_q.size()), 32'(vecs[v].n_order));
         for (int k = 0; k < int'(vecs[v].n_order) && k < order_q.size(); k++)
            check("grant_order", 32'(order_q[k]), 32'(vecs[v].order[4*k +: 4]));
         check("gnt_multi_hot", 32'(multi_bad), 32'd0);
         check("ctl_hold", 32'(ctl_bad), 32'd0);
         check("gnt_idle", 32'(gnt), 32'd0);
      end

      // Requester drops req one cycle after grant; transaction still completes
      exp_w    = 6'd2;
      exp_tied = 1'b0;
      do_reset();
      req_words = {N_REQ{6'd2}};
      req_tied  = '0;
      req       = 4'b0010;
      ok = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         if (gnt[1] === 1'b1) begin
            ok = 1;
            break;
         end
      end
      check("drop_grant_seen", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      req = '0;
      wait_done(1, 200, "drop");
      repeat (4) @(posedge clk);
      #1;
      check("drop_rx1", 32'(rx_cnt[1]), 32'd2);
      check("drop_done1", 32'(done_cnt[1]), 32'd1);

      // m_valid edge while idle must not produce rx_valid
      inject_req++;
      repeat (6) @(posedge clk);
      #1;
      check("idle_edge_rx", 32'(rx_cnt[0] + rx_cnt[1] + rx_cnt[2] + rx_cnt[3]), 32'd2);
      check("idle_edge_done", 32'(done_cnt[1]), 32'd1);

      // Reset mid-transaction discards the transfer without a done pulse
      exp_w = 6'd3;
      do_reset();
      req_words = {N_REQ{6'd3}};
      req       = 4'b0001;
      ok = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #1;
         if (rx_cnt[0] >= 1) begin
            ok = 1;
            break;
         end
      end
      req = '0;
      check("midrst_first_word", 32'(ok), 32'd1);
      n_rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("midrst_done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3]), 32'd0);
      check("midrst_rx", 32'(rx_cnt[0]), 32'd0);
      check("midrst_gnt", 32'(gnt), 32'd0);
      check("midrst_spi_en", 32'(spi_en_cnt), 32'd0);

`ifdef SPI_ARB_WATCHDOG_EN
      // Silent master: each winner aborts WDOG cycles after START, next requester follows
      exp_w = 6'd1;
      hang  = 1;
      do_reset();
      req_words = {N_REQ{6'd1}};
      req       = 4'b0011;
      ok = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #1;
         if (err_cnt >= 2) begin
            ok = 1;
            break;
         end
      end
      req = '0;
      check("wdog_two_aborts", 32'(ok), 32'd1);
      check("wdog_first", 32'(err_q.size() > 0 ? err_q[0] : -1), 32'd0);
      check("wdog_second", 32'(err_q.size() > 1 ? err_q[1] : -1), 32'd1);
      check("wdog_latency", 32'(err_lat), 32'(WDOG));
      repeat (4) @(posedge clk);
      #1;
      check("wdog_no_done", 32'(done_cnt[0] + done_cnt[1]), 32'd0);
      check("wdog_gnt_idle", 32'(gnt), 32'd0);
      hang = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one spi_master, range 2..8.
REQ-002 Parameter DATA_BITS, default 8: word width, equal to the attached spi_master DATA_BITS.
REQ-003 Parameter WDOG_CYCLES, default 1024: watchdog limit in clk cycles per word; used only with SPI_ARB_WATCHDOG_EN.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 n_rst  in  1  reset, asynchronous, active-low.
REQ-006 req  in  N_REQ  per-requester transaction request, level.
REQ-007 req_words  in  6*N_REQ  per-requester word count, slice i = [6i+5:6i].
REQ-008 req_tied  in  N_REQ  per-requester keep-SS-low-between-words flag.
REQ-009 req_data  in  DATA_BITS*N_REQ  per-requester current TX word.
REQ-010 gnt  out  N_REQ  one-hot grant, all-zero when idle.
REQ-011 rx_valid  out  N_REQ  one-cycle pulse to granted requester per received word.
REQ-012 rx_data  out  DATA_BITS  received word, valid while any rx_valid bit is high.
REQ-013 done  out  N_REQ  one-cycle pulse to granted requester at transaction end.
REQ-014 m_spi_en, m_tied_SS  out  1 each; m_data_in  out  DATA_BITS; m_data_words  out  6: spi_master control.
REQ-015 m_ready, m_valid  in  1 each; m_data_out  in  DATA_BITS: spi_master status.
REQ-016 err  out  N_REQ  one-cycle watchdog abort pulse; present only with SPI_ARB_WATCHDOG_EN.

Function
REQ-017 FSM states: IDLE, START, BUSY, DONE.
REQ-018 IDLE: when m_ready=1 and req!=0, select winner round-robin starting at index (last+1) mod N_REQ; register gnt and go to START next cycle.
REQ-019 START: m_spi_en=1 for exactly this one cycle; latch word count W; go to BUSY.
REQ-020 W = req_words slice of winner, with 0 treated as 1; m_data_words=W, m_tied_SS=req_tied of winner, both held constant from START through DONE.
REQ-021 m_data_in = req_data slice of granted requester, combinational mux; 0 when gnt=0.
REQ-022 BUSY: each rising edge of m_valid (m_valid=1 and previous-cycle m_valid=0) increments the word counter, pulses rx_valid[winner] the same cycle, and drives rx_data=m_data_out.
REQ-023 Requester advances req_data to its next word on its rx_valid pulse; the arbiter does not buffer TX data.
REQ-024 BUSY -> DONE on the edge that makes the count equal W.
REQ-025 DONE: done[winner]=1 for one cycle, last=winner, gnt cleared next cycle, return to IDLE.
REQ-026 Deasserting req during START/BUSY does not abort; the transaction completes and done still pulses.
REQ-027 m_valid edges outside BUSY are ignored; rx_valid stays 0.
REQ-028 Minimum gap between consecutive grants is 1 IDLE cycle; new grants wait for m_ready=1.

Reset
REQ-029 Asynchronous reset, n_rst=0: state=IDLE, gnt=0, rx_valid=0, done=0, err=0, m_spi_en=0, m_data_words=0, m_tied_SS=0, rx_data=0, word counter=0, last=N_REQ-1 (requester 0 wins first).
REQ-030 Reset mid-transaction discards the transaction with no done pulse; the spi_master is reset by the same n_rst.

Configuration
REQ-031 With SPI_ARB_WATCHDOG_EN defined: a counter cleared on START and on each m_valid edge; reaching WDOG_CYCLES in BUSY pulses err[winner] for one cycle, clears gnt, skips done, sets last=winner, and returns to IDLE.
REQ-032 Without SPI_ARB_WATCHDOG_EN: no err port, no watchdog counter; BUSY waits indefinitely.

Verification
REQ-033 Reset, then req=4'b0001 with W=1 and data 8'hA5, MISO looped to MOSI -> single m_spi_en pulse; rx_valid[0] once with rx_data=8'hA5; done[0] once.
REQ-034 req=4'b1111 held, W=1 each -> grants in order 0,1,2,3,0; gnt is never multi-hot.
REQ-035 req[2] with req_words=3, req_tied=1 -> one m_spi_en pulse, three rx_valid[2] pulses, m_tied_SS=1 throughout, done[2] after the third.
REQ-036 req_words=0 -> behaves as W=1: one rx_valid, then done.
REQ-037 req[1] dropped one cycle after grant with W=2 -> two rx_valid[1] pulses and done[1] still occur.
REQ-038 With SPI_ARB_WATCHDOG_EN, WDOG_CYCLES=16, m_valid tied 0 -> err[winner] pulses 16 cycles after START; FSM returns to IDLE; next requester is granted.
